word_serializer: RTL and testbench

Width-down converter sitting directly downstream of the NoC skid buffer. It accepts one WORD_WIDTH word over a valid/ready handshake and emits it as WORD_WIDTH/PIECE_WIDTH consecutive narrower pieces over a second valid/ready handshake, flagging the final piece. It sustains full output throughput: the next word is accepted in the same cycle the last piece of the current word is consumed.

---
 rtl/word_serializer.sv | 130 +++++++++++++
 tb/tb_word_serializer.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/word_serializer.sv
// -----------------------------------------------------------------------------
// word_serializer
//   Width-down converter. Accepts one WORD_WIDTH word over a valid/ready
//   handshake and replays it as RATIO = WORD_WIDTH/PIECE_WIDTH narrower pieces
//   over a second valid/ready handshake, flagging the final piece with m_last.
//   The next word is accepted on the same edge the last piece is consumed, so
//   the output sustains one piece per cycle with no bubbles between words.
//
//   Build option:
//     WORD_SERIALIZER_MSB_FIRST_EN  defined   -> most significant piece first
//                                   undefined -> least significant piece first
//
//   Ports:
//     clock    in   rising-edge clock
//     reset_n  in   asynchronous active-low reset
//     s_valid  in   upstream word valid
//     s_ready  out  upstream word ready (depends combinationally on m_ready only)
//     s_data   in   upstream word, WORD_WIDTH bits
//     m_valid  out  piece valid (registered)
//     m_ready  in   downstream piece ready
//     m_data   out  current piece, PIECE_WIDTH bits (registered)
//     m_last   out  final piece of the word (registered)
// -----------------------------------------------------------------------------
module word_serializer #(
    parameter int WORD_WIDTH  = 36,
    parameter int PIECE_WIDTH = 9
) (
    input  logic                   clock,
    input  logic                   reset_n,
    input  logic                   s_valid,
    output logic                   s_ready,
    input  logic [WORD_WIDTH-1:0]  s_data,
    output logic                   m_valid,
    input  logic                   m_ready,
    output logic [PIECE_WIDTH-1:0] m_data,
    output logic                   m_last
);

    localparam int RATIO = WORD_WIDTH / PIECE_WIDTH;
    localparam int IDX_W = (RATIO > 1) ? $clog2(RATIO) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(RATIO - 1);

    generate
        if ((WORD_WIDTH % PIECE_WIDTH) != 0 || RATIO < 1) begin : g_param_check
            $error("word_serializer: WORD_WIDTH must be a positive multiple of PIECE_WIDTH");
        end
    endgenerate

    typedef enum logic {
        EMPTY   = 1'b0,
        SENDING = 1'b1
    } state_e;

    state_e                 state_q;
    logic [WORD_WIDTH-1:0]  word_q;
    logic [IDX_W-1:0]       idx_q;
    logic                   m_valid_q;
    logic                   m_last_q;
    logic [PIECE_WIDTH-1:0] m_data_q;

    logic                   last_piece;
    logic                   xfer;
    logic                   accept;
    logic [IDX_W-1:0]       idx_d;

    // Select piece k of a word. The loop compares against every legal index
    // so the mux never addresses past RATIO-1 for non-power-of-two ratios.
    function automatic logic [PIECE_WIDTH-1:0] piece_sel(
        input logic [WORD_WIDTH-1:0] w,
        input logic [IDX_W-1:0]      k
    );
        logic [PIECE_WIDTH-1:0] r;
        r = '0;
        for (int i = 0; i < RATIO; i++) begin
            if (k == IDX_W'(i)) begin
`ifdef WORD_SERIALIZER_MSB_FIRST_EN
                r = w[WORD_WIDTH-1-i*PIECE_WIDTH -: PIECE_WIDTH];
`else
                r = w[i*PIECE_WIDTH +: PIECE_WIDTH];
`endif
            end
        end
        return r;
    endfunction

    assign last_piece = (idx_q == LAST_IDX);
    assign xfer       = m_valid_q && m_ready;
    // Ready while empty, or when the final piece leaves this cycle; this lets
    // the next word land on the same edge and keeps the output bubble-free.
    assign s_ready    = (state_q == EMPTY) || (m_ready && last_piece);
    assign accept     = s_valid && s_ready;
    // Only consumed when last_piece is false, so it never exceeds RATIO-1.
    assign idx_d      = idx_q + 1'b1;

    // Outputs are registered: on load the first piece is pre-selected from
    // s_data, on each non-final transfer the following piece is pre-selected.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= EMPTY;
            word_q    <= '0;
            idx_q     <= '0;
            m_valid_q <= 1'b0;
            m_last_q  <= 1'b0;
            m_data_q  <= '0;
        end else if (accept) begin
            // Covers both an idle load and a load overlapping the last piece.
            state_q   <= SENDING;
            word_q    <= s_data;
            idx_q     <= '0;
            m_valid_q <= 1'b1;
            m_data_q  <= piece_sel(s_data, '0);
            m_last_q  <= (RATIO == 1);
        end else if (xfer) begin
            if (last_piece) begin
                state_q   <= EMPTY;
                m_valid_q <= 1'b0;
                m_last_q  <= 1'b0;
            end else begin
                idx_q    <= idx_d;
                m_data_q <= piece_sel(word_q, idx_d);
                m_last_q <= (idx_d == LAST_IDX);
            end
        end
    end

    assign m_valid = m_valid_q;
    assign m_data  = m_data_q;
    assign m_last  = m_last_q;

endmodule

// File: tb/tb_word_serializer.sv
// -----------------------------------------------------------------------------
// tb_word_serializer
//   Drives two instances: the default 36->9 serializer (a_*) and a RATIO=1
//   pipeline-register build (b_*). A queue-based reference model expands each
//   accepted word into its expected pieces with plain shifts and masks.
// -----------------------------------------------------------------------------
module tb_word_serializer;

    typedef struct {
        logic [35:0] d;
        logic        l;
    } piece_t;

    logic        clock   = 1'b0;
    logic        reset_n = 1'b0;

    logic        a_s_valid, a_s_ready, a_m_valid, a_m_ready, a_m_last;
    logic [35:0] a_s_data;
    logic [8:0]  a_m_data;

    logic        b_s_valid, b_s_ready, b_m_valid, b_m_ready, b_m_last;
    logic [35:0] b_s_data;
    logic [35:0] b_m_data;

    int cmp_cnt = 0;
    int err_cnt = 0;

    piece_t aq[$];
    piece_t bq[$];

    // Per-step observations and handshake outcomes
    logic        a_obs_v, a_obs_l, a_obs_r;
    logic [8:0]  a_obs_d;
    logic        a_acc, a_xfer, b_acc, b_xfer;
    int          b_out;

    logic [8:0]  dir_exp [4];

    always #5 clock = ~clock;

    word_serializer #(.WORD_WIDTH(36), .PIECE_WIDTH(9)) u_dut (
        .clock(clock), .reset_n(reset_n),
        .s_valid(a_s_valid), .s_ready(a_s_ready), .s_data(a_s_data),
        .m_valid(a_m_valid), .m_ready(a_m_ready), .m_data(a_m_data), .m_last(a_m_last)
    );

    word_serializer #(.WORD_WIDTH(36), .PIECE_WIDTH(36)) u_r1 (
        .clock(clock), .reset_n(reset_n),
        .s_valid(b_s_valid), .s_ready(b_s_ready), .s_data(b_s_data),
        .m_valid(b_m_valid), .m_ready(b_m_ready), .m_data(b_m_data), .m_last(b_m_last)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        cmp_cnt++;
        assert (obs === exp) else begin
            err_cnt++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [35:0] rnd36();
        return {4'($urandom_range(0, 15)), 32'($urandom)};
    endfunction

    // Piece k of a 36-bit word in 9-bit pieces, in the build's emission order.
    function automatic logic [8:0] ref_piece(input logic [35:0] w, input int k);
        int sh;
`ifdef WORD_SERIALIZER_MSB_FIRST_EN
        sh = (3 - k) * 9;
`else
        sh = k * 9;
`endif
        return 9'((w >> sh) & 36'h1FF);
    endfunction

    task automatic push_a(input logic [35:0] w);
        for (int k = 0; k < 4; k++) aq.push_back('{d: 36'(ref_piece(w, k)), l: (k == 3)});
    endtask

    // One clock: sample and check at the falling edge, then advance the model
    // by whatever handshakes the rising edge completes.
    task automatic step();
        logic a_ev, a_er, b_ev, b_er;
        @(negedge clock);
        a_obs_v = a_m_valid; a_obs_l = a_m_last; a_obs_r = a_s_ready; a_obs_d = a_m_data;

        a_ev = (aq.size() != 0);
        a_er = (aq.size() == 0) || (a_m_ready && aq.size() == 1);
        check("a_m_valid", 64'(a_m_valid), 64'(a_ev));
        check("a_s_ready", 64'(a_s_ready), 64'(a_er));
        if (a_ev) begin
            check("a_m_data", 64'(a_m_data), 64'(aq[0].d));
            check("a_m_last", 64'(a_m_last), 64'(aq[0].l));
        end

        b_ev = (bq.size() != 0);
        b_er = (bq.size() == 0) || b_m_ready;
        check("b_m_valid", 64'(b_m_valid), 64'(b_ev));
        check("b_s_ready", 64'(b_s_ready), 64'(b_er));
        if (b_ev) begin
            check("b_m_data", 64'(b_m_data), 64'(bq[0].d));
            check("b_m_last", 64'(b_m_last), 64'(bq[0].l));
        end

        a_xfer = a_ev && a_m_ready;
        a_acc  = a_s_valid && a_er;
        b_xfer = b_ev && b_m_ready;
        b_acc  = b_s_valid && b_er;

        @(posedge clock);
        #1;
        if (a_xfer) void'(aq.pop_front());
        if (a_acc)  push_a(a_s_data);
        if (b_xfer) begin void'(bq.pop_front()); b_out++; end
        if (b_acc)  bq.push_back('{d: b_s_data, l: 1'b1});
    endtask

    initial begin
        int nacc, vcnt, first_v, last_v, a_left, b_left, iter;
        logic [35:0] w;
        logic [8:0]  hold_d;

`ifdef WORD_SERIALIZER_MSB_FIRST_EN
        dir_exp = '{9'h024, 9'h0D1, 9'h0B3, 9'h189};
`else
        dir_exp = '{9'h189, 9'h0B3, 9'h0D1, 9'h024};
`endif
        a_s_valid = 0; a_s_data = '0; a_m_ready = 0;
        b_s_valid = 0; b_s_data = '0; b_m_ready = 0;
        b_out = 0;

        // Reset state
        repeat (2) @(posedge clock);
        #1;
        check("rst_m_valid", 64'(a_m_valid), 64'd0);
        check("rst_m_last",  64'(a_m_last),  64'd0);
        check("rst_m_data",  64'(a_m_data),  64'd0);
        check("rst_s_ready", 64'(a_s_ready), 64'd1);
        check("rst_b_valid", 64'(b_m_valid), 64'd0);
        reset_n = 1;
        step();

        // Directed word, m_ready held high
        a_m_ready = 1;
        a_s_data  = 36'h123456789;
        a_s_valid = 1;
        step();
        check("dir_accept", 64'(a_acc), 64'd1);
        a_s_valid = 0;
        for (int k = 0; k < 4; k++) begin
            step();
            check("dir_valid",  64'(a_obs_v), 64'd1);
            check("dir_piece",  64'(a_obs_d), 64'(dir_exp[k]));
            check("dir_last",   64'(a_obs_l), 64'(k == 3));
            check("dir_sready", 64'(a_obs_r), 64'(k == 3));
        end
        step();
        check("dir_idle", 64'(a_obs_v), 64'd0);

        // Back-to-back words with s_valid held high
        a_s_valid = 1; a_s_data = rnd36();
        nacc = 0; vcnt = 0; first_v = -1; last_v = -1;
        for (int t = 0; t < 40 && (nacc < 3 || aq.size() != 0); t++) begin
            step();
            if (a_obs_v) begin
                vcnt++;
                if (first_v < 0) first_v = t;
                last_v = t;
            end
            if (a_acc) begin
                nacc++;
                if (nacc == 3) a_s_valid = 0; else a_s_data = rnd36();
            end
        end
        check("b2b_accepts", 64'(nacc), 64'd3);
        check("b2b_pieces",  64'(vcnt), 64'd12);
        check("b2b_nogap",   64'(last_v - first_v + 1), 64'd12);

        // Backpressure at piece 2
        a_s_data = rnd36(); a_s_valid = 1;
        step();
        a_s_valid = 0;
        step(); step();
        a_m_ready = 0;
        step();
        hold_d = a_obs_d;
        check("bp_piece2", 64'(hold_d), 64'(ref_piece(a_s_data, 2)));
        for (int k = 0; k < 2; k++) begin
            step();
            check("bp_hold_data", 64'(a_obs_d), 64'(hold_d));
            check("bp_hold_last", 64'(a_obs_l), 64'd0);
            check("bp_sready",    64'(a_obs_r), 64'd0);
        end
        a_m_ready = 1;
        step();
        check("bp_resume", 64'(a_obs_d), 64'(hold_d));
        step(); step();
        check("bp_drained", 64'(aq.size()), 64'd0);

        // Reset in the middle of a word
        a_s_data = rnd36(); a_s_valid = 1;
        step();
        a_s_valid = 0;
        step(); step();
        #2 reset_n = 0;
        #1;
        check("mid_rst_valid",  64'(a_m_valid), 64'd0);
        check("mid_rst_last",   64'(a_m_last),  64'd0);
        check("mid_rst_sready", 64'(a_s_ready), 64'd1);
        aq.delete(); bq.delete();
        @(posedge clock);
        #1 reset_n = 1;
        w = rnd36();
        a_s_data = w; a_s_valid = 1;
        step();
        a_s_valid = 0;
        step();
        check("post_rst_piece0", 64'(a_obs_d), 64'(ref_piece(w, 0)));
        repeat (4) step();

        // Random traffic on both instances
        a_left = 30; b_left = 5; b_out = 0;
        a_s_data = rnd36(); b_s_data = rnd36();
        iter = 0;
        while ((a_left > 0 || b_left > 0 || aq.size() != 0 || bq.size() != 0) && iter < 3000) begin
            a_s_valid = (a_left > 0) && ($urandom_range(0, 3) != 0);
            b_s_valid = (b_left > 0) && ($urandom_range(0, 2) != 0);
            a_m_ready = ($urandom_range(0, 3) != 0);
            b_m_ready = ($urandom_range(0, 1) != 0);
            step();
            if (a_acc) begin a_left--; a_s_data = rnd36(); end
            if (b_acc) begin b_left--; b_s_data = rnd36(); end
            iter++;
        end
        a_s_valid = 0; b_s_valid = 0;
        check("rand_a_left",  64'(a_left), 64'd0);
        check("rand_b_left",  64'(b_left), 64'd0);
        check("rand_drained", 64'(aq.size() + bq.size()), 64'd0);
        check("r1_out_count", 64'(b_out), 64'd5);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
        $finish;
    end

endmodule
